// File: rtl/irq_arbiter_pkg.sv
// Shared definitions for the interrupt arbiter.
//  - default sizing shared with the rest of the device (sources, id width, holdoff)
//  - 2-bit FSM state encoding for the grant sequencer
package irq_arbiter_pkg;

  localparam int DEF_NUM_SOURCES    = 4;
  localparam int DEF_ID_BITS        = 3;
  localparam int DEF_HOLDOFF_CYCLES = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_ASSERT  = 2'd2,
    ST_HOLDOFF = 2'd3
  } arb_state_t;

endpackage

// File: rtl/irq_arbiter_rr_pick.sv
// Combinational round-robin picker.
//  req  : pending request vector, bit i = source i
//  last : most recently granted source; scanning starts at last+1
//  pick : first requesting source found, wrapping NUM_SOURCES-1 -> 0
//  any  : at least one request present (pick is 0 when clear)
module rr_pick
  import irq_arbiter_pkg::*;
#(
  parameter int NUM_SOURCES = DEF_NUM_SOURCES,
  parameter int ID_BITS     = DEF_ID_BITS
) (
  input  logic [NUM_SOURCES-1:0] req,
  input  logic [ID_BITS-1:0]     last,
  output logic [ID_BITS-1:0]     pick,
  output logic                   any
);

  always_comb begin
    int idx;
    pick = '0;
    any  = 1'b0;
    idx  = 0;
    // Offset 1..NUM_SOURCES: the previous winner is checked last.
    for (int i = 1; i <= NUM_SOURCES; i++) begin
      idx = int'(last) + i;
      if (idx >= NUM_SOURCES) idx = idx - NUM_SOURCES;
      if (!any && req[idx]) begin
        pick = ID_BITS'(idx);
        any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_arbiter.sv
// Interrupt arbiter: collects per-module interrupt lines and presents them to
// the CPU one at a time with a round-robin grant.
//  clk         : system clock
//  nreset      : asynchronous reset, active-low
//  irq_in      : per-source level requests (async), rising edge = new event
//  irq_mask    : 1 = ignore rising edges of that source
//  ack         : CPU acknowledge level (async), rising edge clears the grant
//  interrupt   : active-low CPU interrupt, low only while a grant is presented
//  irq_id      : granted source id, held outside ASSERT
//  irq_pending : pending register for status read-back
module irq_arbiter
  import irq_arbiter_pkg::*;
#(
  parameter int NUM_SOURCES    = DEF_NUM_SOURCES,
  parameter int ID_BITS        = DEF_ID_BITS,
  parameter int HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic [NUM_SOURCES-1:0] irq_in,
  input  logic [NUM_SOURCES-1:0] irq_mask,
  input  logic                   ack,
  output logic                   interrupt,
  output logic [ID_BITS-1:0]     irq_id,
  output logic [NUM_SOURCES-1:0] irq_pending
);

  localparam int CNT_W = $clog2(HOLDOFF_CYCLES + 1);

  // [0],[1] synchronise; [2] is the previous synced value for edge detect.
  logic [2:0][NUM_SOURCES-1:0] irq_sync;
  logic [2:0]                  ack_sync;
  logic [NUM_SOURCES-1:0]      irq_rise, irq_set, irq_clr, pending;
  logic                        ack_rise;

  arb_state_t                  state, state_nxt;
  logic [ID_BITS-1:0]          rr_last, pick;
  logic                        any;
  logic [CNT_W-1:0]            holdoff_cnt;
  logic                        ack_take;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      irq_sync <= '0;
      ack_sync <= '0;
    end else begin
      irq_sync <= {irq_sync[1:0], irq_in};
      ack_sync <= {ack_sync[1:0], ack};
    end
  end

  assign irq_rise = irq_sync[1] & ~irq_sync[2];
  assign ack_rise = ack_sync[1] & ~ack_sync[2];

  // Ack only counts while a grant is actually presented.
  assign ack_take = (state == ST_ASSERT) && ack_rise;
  assign irq_set  = irq_rise & ~irq_mask;
  assign irq_clr  = ack_take ? (NUM_SOURCES'(1) << irq_id) : '0;

  // Set after clear: a fresh event on the acked source is kept.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) pending <= '0;
    else         pending <= (pending & ~irq_clr) | irq_set;
  end

  rr_pick #(
    .NUM_SOURCES (NUM_SOURCES),
    .ID_BITS     (ID_BITS)
  ) u_pick (
    .req  (pending),
    .last (rr_last),
    .pick (pick),
    .any  (any)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (any) state_nxt = ST_GRANT;
      ST_GRANT:   state_nxt = ST_ASSERT;
      ST_ASSERT:  if (ack_take) state_nxt = ST_HOLDOFF;
      ST_HOLDOFF: if (holdoff_cnt == CNT_W'(1)) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Grant id and rr pointer change only in GRANT, so irq_id never moves
  // while the CPU can see it.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      irq_id  <= '0;
      rr_last <= ID_BITS'(NUM_SOURCES - 1);
    end else if (state == ST_GRANT) begin
      irq_id  <= pick;
      rr_last <= pick;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)                                   holdoff_cnt <= '0;
    else if (ack_take)                             holdoff_cnt <= CNT_W'(HOLDOFF_CYCLES);
    else if (state == ST_HOLDOFF && holdoff_cnt != '0) holdoff_cnt <= holdoff_cnt - CNT_W'(1);
  end

  // Decoded straight from the state flop so reset deasserts it immediately.
  assign interrupt   = (state != ST_ASSERT);
  assign irq_pending = pending;

endmodule
